// File: rtl/write_fifo_defs.sv
// rtl/write_fifo_defs.sv - shared defaults, pointer-width macro and reset constants for write_fifo
// Pointers carry one extra wrap bit beyond the storage index.
`define WRITE_FIFO_PTR_W(depth) ($clog2(depth) + 1)

package write_fifo_defs;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH      = 16;
  localparam int unsigned FIFO_RST_DATA   = 0;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port register array with a registered read port
// Read data register holds its value when re_i is low; the array itself is never reset.
module fifo_mem
  import write_fifo_defs::*;
#(
  parameter  int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int unsigned DEPTH      = FIFO_DEPTH,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= DATA_WIDTH'(FIFO_RST_DATA);
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/write_fifo.sv
// rtl/write_fifo.sv - single-clock drop-on-full FIFO behind the multi-writer arbiter
// Optional sticky drop flag: WRITE_FIFO_OVERFLOW_EN.
module write_fifo
  import write_fifo_defs::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow
);

  localparam int unsigned PTR_W = `WRITE_FIFO_PTR_W(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic             rd_ok, wr_ok;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;

  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign rd_ok = i_re && !o_empty;
  assign wr_ok = i_we && (!o_full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = rd_ok;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  assign o_valid = valid_q;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[PTR_W-2:0]),
    .wdata_i (i_data),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q[PTR_W-2:0]),
    .rdata_o (o_data)
  );

`ifdef WRITE_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic drop;

  assign drop = i_we && o_full && !rd_ok;

  always_comb begin
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_fifo.sv
// tb/tb_write_fifo.sv - scoreboard bench for write_fifo (DEPTH 16, 8-bit data)
module tb_write_fifo;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_we = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_re = 1'b0;
  logic       o_full, o_valid, o_empty, o_overflow;
  logic [7:0] o_data;
  logic [4:0] o_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         mcount = 0;
  bit         exp_v = 1'b0;
  logic [7:0] exp_d = 8'h00;
  bit         mov = 1'b0;

  always #5 clk = ~clk;

  write_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_we       (i_we),
    .i_data     (i_data),
    .o_full     (o_full),
    .i_re       (i_re),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  // Drive one cycle and update the scoreboard; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit we, input logic [7:0] d, input bit re);
    bit r, w;
    i_we = we; i_data = d; i_re = re;
    r = re && (mcount > 0);
    w = we && ((mcount < 16) || r);
    exp_v = r;
    if (r) exp_d = sb.pop_front();
    if (w) sb.push_back(d);
    if (we && !w) mov = 1'b1;
    mcount = mcount + (w ? 1 : 0) - (r ? 1 : 0);
    @(posedge clk); #1;
    i_we = 1'b0; i_re = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete(); mcount = 0; exp_v = 1'b0; exp_d = 8'h00; mov = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_reset_n = 1'b1;
    model_reset();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
    checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_overflow); end
  endtask

  task automatic test_basic();
    logic [7:0] want [3];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    for (int i = 0; i < 3; i++) cyc(1'b1, want[i], 1'b0);
    checks++; if (o_count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d want 3", o_count); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", i, o_valid); end
      checks++; if (o_data !== want[i] || o_data !== exp_d) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, o_data, want[i]); end
    end
    cyc(1'b0, 8'h00, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", o_valid); end
    checks++; if (o_data !== 8'h33) begin errors++; $display("FAIL basic_hold got %h want 33", o_data); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", o_empty); end
    cyc(1'b0, 8'h00, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_read_empty got %b want 0", o_valid); end
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", o_full); end
    checks++; if (o_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", o_count); end
    cyc(1'b1, 8'hAA, 1'b0);
    checks++; if (o_count !== 5'd16) begin errors++; $display("FAIL drop_count got %0d want 16", o_count); end
`ifdef WRITE_FIFO_OVERFLOW_EN
    checks++; if (o_overflow !== 1'b1 || !mov) begin errors++; $display("FAIL drop_ovf got %b want 1", o_overflow); end
`else
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL drop_ovf got %b want 0", o_overflow); end
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (o_valid !== 1'b1 || o_data !== 8'(i) || o_data !== exp_d) begin
        errors++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, 8'(i)); end
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", o_empty); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    checks++; if (o_count !== 5'd16) begin errors++; $display("FAIL fullrw_count got %0d want 16", o_count); end
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h00) begin errors++; $display("FAIL fullrw_data got v=%b d=%h want v=1 d=00", o_valid, o_data); end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (o_valid !== 1'b1 || o_data !== exp_d) begin
        errors++; $display("FAIL fullrw_drain[%0d] got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, exp_d); end
    end
    checks++; if (o_data !== 8'h55) begin errors++; $display("FAIL fullrw_last got %h want 55", o_data); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b want 1", o_empty); end
  endtask

  task automatic test_empty_rw();
    cyc(1'b1, 8'h77, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL emptyrw_valid got %b want 0", o_valid); end
    checks++; if (o_count !== 5'd1) begin errors++; $display("FAIL emptyrw_count got %0d want 1", o_count); end
    cyc(1'b0, 8'h00, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h77) begin errors++; $display("FAIL emptyrw_read got v=%b d=%h want v=1 d=77", o_valid, o_data); end
  endtask

  task automatic test_reset_wrap();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    i_reset_n = 1'b0; i_re = 1'b1;
    @(posedge clk); #1;
    i_reset_n = 1'b1; i_re = 1'b0;
    model_reset();
    checks++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL midreset_count got %0d want 0", o_count); end
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL midreset_read got v=%b d=%h want v=0 d=00", o_valid, o_data); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL midreset_ovf got %b want 0", o_overflow); end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'h80 + 8'(i), (i % 3) != 0);
      checks++; if (o_valid !== exp_v || o_data !== exp_d || o_count !== 5'(mcount)) begin
        errors++; $display("FAIL wrap[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d", i, o_valid, o_data, o_count, exp_v, exp_d, mcount); end
    end
    for (int k = 0; k < 64 && mcount > 0; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (o_valid !== 1'b1 || o_data !== exp_d) begin
        errors++; $display("FAIL wrap_drain[%0d] got v=%b d=%h want v=1 d=%h", k, o_valid, o_data, exp_d); end
    end
    checks++; if (o_empty !== 1'b1 || o_count !== 5'd0) begin errors++; $display("FAIL wrap_end got e=%b c=%0d want e=1 c=0", o_empty, o_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_drop();
    test_full_rw();
    test_empty_rw();
    test_reset_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
